// File: rtl/mant_mul_iter.sv
// Iterative shift-and-add mantissa multiplier: one CLA add of the multiplicand into
// the accumulator's upper half per multiplier bit, full product over valid/ready.

module CLA_adder_top #(
    parameter int WIDTH = 24,
    parameter int FANIN = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    localparam int NG = (WIDTH + FANIN - 1) / FANIN;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry inside a group is a flat function of the group carry-in and the
    // group's generate/propagate terms; groups chain on their last carry.
    always_comb begin
        logic gen;
        logic prop;
        logic cg;
        c    = '0;
        c[0] = c_in;
        for (int grp = 0; grp < NG; grp++) begin
            cg = c[grp*FANIN];
            for (int k = 0; k < FANIN; k++) begin
                if (grp*FANIN + k < WIDTH) begin
                    gen  = 1'b0;
                    prop = 1'b1;
                    for (int j = k; j >= 0; j--) begin
                        gen  = gen | (prop & g[grp*FANIN + j]);
                        prop = prop & p[grp*FANIN + j];
                    end
                    c[grp*FANIN + k + 1] = gen | (prop & cg);
                end
            end
        end
    end

    assign sum   = p ^ c[WIDTH-1:0];
    assign c_out = c[WIDTH];
endmodule

module mant_mul_iter #(
    parameter int WIDTH = 24,
    parameter int FANIN = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [2*WIDTH-1:0] o_product,
    output logic               o_busy
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   mcand;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] product_q;

    logic               accept;
    logic               zero_op;
    logic               last_step;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   cla_sum;
    logic               cla_cout;
    logic [2*WIDTH-1:0] acc_shifted;

    assign accept    = i_valid && (state == IDLE);
    assign zero_op   = (i_a == '0) || (i_b == '0);
    assign last_step = (state == RUN) && (count == CNT_W'(WIDTH - 1));
    assign addend    = acc_lo[0] ? mcand : '0;

    CLA_adder_top #(
        .WIDTH (WIDTH),
        .FANIN (FANIN)
    ) u_cla (
        .a     (acc_hi),
        .b     (addend),
        .c_in  (1'b0),
        .sum   (cla_sum),
        .c_out (cla_cout)
    );

    // acc_hi + mcand never exceeds 2^(WIDTH+1)-2, so carry-out plus sum is exact
    // and the right shift keeps the carry as the new MSB.
    assign acc_shifted = {cla_cout, cla_sum, acc_lo[WIDTH-1:1]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        o_valid   = 1'b0;
        o_busy    = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (accept) begin
                    state_nxt = zero_op ? DONE : RUN;
                end
            end
            RUN: begin
                o_busy = 1'b1;
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_hi    <= '0;
            acc_lo    <= '0;
            mcand     <= '0;
            count     <= '0;
            product_q <= '0;
        end else if (accept) begin
            if (zero_op) begin
                product_q <= '0;
            end else begin
                mcand  <= i_a;
                acc_hi <= '0;
                acc_lo <= i_b;
                count  <= '0;
            end
        end else if (state == RUN) begin
            acc_hi <= acc_shifted[2*WIDTH-1:WIDTH];
            acc_lo <= acc_shifted[WIDTH-1:0];
            if (last_step) begin
                product_q <= acc_shifted;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign o_product = product_q;
endmodule

// File: tb/tb_mant_mul_iter.sv
// Directed bench for mant_mul_iter: an 8-bit instance for latency/handshake scenarios
// and a 24-bit instance for corner and random products plus throughput.

module tb_mant_mul_iter;
    logic clk;
    logic rst_n;

    logic        v8, rdy8, ordy8, ov8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] prod8;

    logic        v24, rdy24, ordy24, ov24, busy24;
    logic [23:0] a24, b24;
    logic [47:0] prod24;

    int checks;
    int errors;

    mant_mul_iter #(.WIDTH(8), .FANIN(4)) dut8 (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (v8),
        .o_ready   (ordy8),
        .i_a       (a8),
        .i_b       (b8),
        .o_valid   (ov8),
        .i_ready   (rdy8),
        .o_product (prod8),
        .o_busy    (busy8)
    );

    mant_mul_iter #(.WIDTH(24), .FANIN(4)) dut24 (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (v24),
        .o_ready   (ordy24),
        .i_a       (a24),
        .i_b       (b24),
        .o_valid   (ov24),
        .i_ready   (rdy24),
        .o_product (prod24),
        .o_busy    (busy24)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only: accept one operand pair and wait (bounded) for o_valid.
    // edges counts the accept edge as edge 1.
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        output int edges, output logic [15:0] p, output logic saw_busy);
        @(negedge clk);
        a8 = a; b8 = b; v8 = 1'b1;
        @(posedge clk);
        edges = 1;
        #1;
        v8 = 1'b0;
        saw_busy = busy8;
        while (!ov8 && edges < 40) begin
            @(posedge clk);
            edges++;
            #1;
            saw_busy |= busy8;
        end
        p = prod8;
    endtask

    task automatic run24(input logic [23:0] a, input logic [23:0] b,
                         output int edges, output logic [47:0] p);
        @(negedge clk);
        a24 = a; b24 = b; v24 = 1'b1;
        @(posedge clk);
        edges = 1;
        #1;
        v24 = 1'b0;
        while (!ov24 && edges < 60) begin
            @(posedge clk);
            edges++;
            #1;
        end
        p = prod24;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        v8 = 0; rdy8 = 1; a8 = '0; b8 = '0;
        v24 = 0; rdy24 = 1; a24 = '0; b24 = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ordy8, ov8, busy8} !== 3'b100) begin
            errors++;
            $display("FAIL reset_ctrl8 got %b want 100", {ordy8, ov8, busy8});
        end
        checks++;
        if (prod8 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_prod8 got %h want 0000", prod8);
        end
        checks++;
        if ({ordy24, ov24, busy24} !== 3'b100 || prod24 !== 48'h0) begin
            errors++;
            $display("FAIL reset_24 got %b/%h want 100/0", {ordy24, ov24, busy24}, prod24);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ordy8 !== 1'b1 || ov8 !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle got rdy=%b vld=%b want 1/0", ordy8, ov8);
        end
    endtask

    task automatic test_max_operands();
        int edges;
        logic [15:0] p;
        logic sb;
        rdy8 = 1'b1;
        run8(8'hFF, 8'hFF, edges, p, sb);
        checks++;
        if (edges !== 9) begin
            errors++;
            $display("FAIL max_latency got %0d want 9", edges);
        end
        checks++;
        if (p !== 16'hFE01) begin
            errors++;
            $display("FAIL max_product got %h want fe01", p);
        end
        checks++;
        if (sb !== 1'b1) begin
            errors++;
            $display("FAIL max_busy got %b want 1", sb);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ordy8 !== 1'b1 || ov8 !== 1'b0) begin
            errors++;
            $display("FAIL max_release got rdy=%b vld=%b want 1/0", ordy8, ov8);
        end
    endtask

    task automatic test_zero_path();
        int edges;
        logic [15:0] p;
        logic sb;
        rdy8 = 1'b1;
        run8(8'h00, 8'hA5, edges, p, sb);
        checks++;
        if (edges !== 1) begin
            errors++;
            $display("FAIL zero_latency got %0d want 1", edges);
        end
        checks++;
        if (p !== 16'h0000) begin
            errors++;
            $display("FAIL zero_product got %h want 0000", p);
        end
        checks++;
        if (sb !== 1'b0) begin
            errors++;
            $display("FAIL zero_busy got %b want 0", sb);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ordy8 !== 1'b1) begin
            errors++;
            $display("FAIL zero_release got rdy=%b want 1", ordy8);
        end
    endtask

    task automatic test_back_pressure();
        int edges;
        logic [15:0] p;
        logic sb;
        int bad;
        rdy8 = 1'b0;
        run8(8'h81, 8'h03, edges, p, sb);
        checks++;
        if (p !== 16'h0183 || edges !== 9) begin
            errors++;
            $display("FAIL bp_product got %h/%0d want 0183/9", p, edges);
        end
        bad = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (prod8 !== 16'h0183 || ov8 !== 1'b1 || ordy8 !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL bp_hold got %0d bad cycles want 0", bad);
        end
        @(negedge clk);
        rdy8 = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ordy8 !== 1'b1 || ov8 !== 1'b0 || prod8 !== 16'h0183) begin
            errors++;
            $display("FAIL bp_release got rdy=%b vld=%b p=%h want 1/0/0183", ordy8, ov8, prod8);
        end
    endtask

    task automatic test_operand_change();
        int edges;
        rdy8 = 1'b1;
        @(negedge clk);
        a8 = 8'h0D; b8 = 8'h0B; v8 = 1'b1;
        @(posedge clk);
        edges = 1;
        #1;
        v8 = 1'b0;
        while (!ov8 && edges < 40) begin
            @(negedge clk);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            @(posedge clk);
            edges++;
            #1;
        end
        checks++;
        if (prod8 !== 16'h008F || edges !== 9) begin
            errors++;
            $display("FAIL opchg_product got %h/%0d want 008f/9", prod8, edges);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_run();
        int edges;
        logic [15:0] p;
        logic sb;
        logic saw_vld;
        rdy8 = 1'b1;
        @(negedge clk);
        a8 = 8'hC7; b8 = 8'h9E; v8 = 1'b1;
        @(posedge clk);
        #1;
        v8 = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ordy8, ov8, busy8} !== 3'b100 || prod8 !== 16'h0000) begin
            errors++;
            $display("FAIL midrst_outputs got %b/%h want 100/0000", {ordy8, ov8, busy8}, prod8);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        saw_vld = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            saw_vld |= ov8;
        end
        checks++;
        if (saw_vld !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_valid got %b want 0", saw_vld);
        end
        run8(8'h03, 8'h05, edges, p, sb);
        checks++;
        if (p !== 16'h000F || edges !== 9) begin
            errors++;
            $display("FAIL midrst_next got %h/%0d want 000f/9", p, edges);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_w24_products();
        logic [23:0] ca [6];
        logic [23:0] cb [6];
        logic [47:0] exp_p;
        logic [47:0] p;
        int edges;
        int exp_e;
        int bad;
        ca = '{24'h800000, 24'hFFFFFF, 24'h800000, 24'h000001, 24'h000000, 24'hABCDEF};
        cb = '{24'h800000, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h123456, 24'h000000};
        rdy24 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_p = 48'(ca[i]) * 48'(cb[i]);
            exp_e = (ca[i] == 0 || cb[i] == 0) ? 1 : 25;
            run24(ca[i], cb[i], edges, p);
            checks++;
            if (p !== exp_p || edges !== exp_e) begin
                errors++;
                $display("FAIL w24_corner%0d got %h/%0d want %h/%0d", i, p, edges, exp_p, exp_e);
            end
            @(posedge clk);
            #1;
        end
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            logic [23:0] ra;
            logic [23:0] rb;
            ra = 24'($urandom);
            rb = 24'($urandom);
            if (i % 50 == 7) ra = 24'hFFFFFF;
            if (i % 50 == 9) rb = 24'h800000;
            exp_p = 48'(ra) * 48'(rb);
            run24(ra, rb, edges, p);
            checks++;
            if (p !== exp_p) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL w24_random a=%h b=%h got %h want %h", ra, rb, p, exp_p);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        int first;
        int second;
        rdy24 = 1'b1;
        first = -1;
        second = -1;
        @(negedge clk);
        a24 = 24'hC0FFEE; b24 = 24'h9ABCDE; v24 = 1'b1;
        for (int cyc = 0; cyc < 100 && second < 0; cyc++) begin
            if (cyc != 0) @(negedge clk);
            if (ordy24) begin
                if (first < 0) first = cyc;
                else second = cyc;
            end
        end
        v24 = 1'b0;
        checks++;
        if (second - first !== 26) begin
            errors++;
            $display("FAIL w24_throughput got %0d want 26", second - first);
        end
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (ordy24 !== 1'b1 || prod24 !== 48'hC0FFEE * 48'h9ABCDE) begin
            errors++;
            $display("FAIL w24_b2b_product got %b/%h want 1/%h", ordy24, prod24,
                     48'hC0FFEE * 48'h9ABCDE);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_max_operands();
        test_zero_path();
        test_back_pressure();
        test_operand_change();
        test_reset_mid_run();
        test_w24_products();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
